// File: rtl/data_mem_responder_pkg.sv
// Shared MEM-stage bus types: FSM states, operation encoding and request decode.
package mem_bus_pkg;

    localparam int WORD_W     = 32;
    localparam int BYTE_OFF_W = 2;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    typedef enum logic [1:0] {OP_NONE, OP_LOAD, OP_STORE, OP_BAD} op_t;

    // Conflicting strobes or a non-word-aligned address are both served as an error.
    function automatic op_t decode_op(input logic load, input logic store,
                                      input logic [BYTE_OFF_W-1:0] off);
        op_t op;
        op = OP_NONE;
        if (load && store)
            op = OP_BAD;
        else if ((load || store) && (off != '0))
            op = OP_BAD;
        else if (load)
            op = OP_LOAD;
        else if (store)
            op = OP_STORE;
        return op;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage data bus between the pipeline (master) and the data RAM responder (slave).
interface data_mem_responder_if;
    import mem_bus_pkg::*;

    logic [WORD_W-1:0] daddrbus;
    logic [WORD_W-1:0] databus_in;
    logic              load;
    logic              store;
    logic [WORD_W-1:0] databus_out;
    logic              ready;
    logic              stall;
    logic              err;

    modport master (
        output daddrbus, databus_in, load, store,
        input  databus_out, ready, stall, err
    );

    modport slave (
        input  daddrbus, databus_in, load, store,
        output databus_out, ready, stall, err
    );

endinterface

// File: rtl/data_mem_responder_wait_counter.sv
// Loadable 4-bit down-counter that stops at zero and flags it.
module wait_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [3:0] i_value,
    input  logic       i_en,
    output logic       o_done
);

    logic [3:0] r_count;

    always_ff @(posedge clk) begin
        if (reset)
            r_count <= '0;
        else if (i_load)
            r_count <= i_value;
        else if (i_en && (r_count != '0))
            r_count <= r_count - 4'd1;
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/data_mem_responder.sv
// Data RAM responder for the MEM stage: one access per WAIT_STATES+3 cycles,
// IDLE -> BUSY (WAIT_STATES+1 cycles) -> RESP (ready pulse).
module data_mem_responder
    import mem_bus_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t            r_state;
    op_t               r_op;
    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] r_wdata;
    logic [WORD_W-1:0] r_rdata;
    logic              r_ready;
    logic              r_err;
    logic [WORD_W-1:0] r_mem [DEPTH];

    logic w_req;
    logic w_accept;
    logic w_finish;
    logic w_done;
    logic w_unused_addr;

    assign w_req    = bus.load | bus.store;
    assign w_accept = (r_state == IDLE) & w_req & ~reset;
    assign w_finish = (r_state == BUSY) & w_done & ~reset;

    // Upper address bits wrap: only the word index selects a RAM entry.
    assign w_unused_addr = ^{bus.daddrbus[WORD_W-1:IDX_W+BYTE_OFF_W]};

    wait_counter u_wait (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_accept),
        .i_value (4'(WAIT_STATES)),
        .i_en    (r_state == BUSY),
        .o_done  (w_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_op    <= OP_NONE;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= w_finish;
            r_err   <= w_finish && (r_op == OP_BAD);
            if (w_finish && (r_op == OP_LOAD))
                r_rdata <= r_mem[r_idx];
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_idx   <= bus.daddrbus[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];
                        r_wdata <= bus.databus_in;
                        r_op    <= decode_op(bus.load, bus.store, bus.daddrbus[BYTE_OFF_W-1:0]);
                        r_state <= BUSY;
                    end
                end
                BUSY:    if (w_done) r_state <= RESP;
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Store commits on the same edge that enters RESP, so a reset there discards it.
    always_ff @(posedge clk) begin
        if (w_finish && (r_op == OP_STORE))
            r_mem[r_idx] <= r_wdata;
    end

    assign bus.databus_out = r_rdata;
    assign bus.ready       = r_ready;
    assign bus.err         = r_err;
    assign bus.stall       = (r_state == BUSY) | ((r_state == IDLE) & w_req & ~reset);

endmodule
